// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and
// the multi-cycle EX occupancy states.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        MC_IDLE,
        MC_RUN
    } mc_state_t;

endpackage

// File: rtl/hazard_mc_timer.sv
// Tracks how long a multi-cycle EX op (mul/div) still occupies EX and raises
// hold_o until the final cycle, in which the op leaves EX.
module hazard_mc_timer
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic hold_o,
    output logic busy_o
);

    localparam int  CW    = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam bit  MC_ON = (MC_LAT > 1);

    mc_state_t      state_q, state_d;
    logic [CW-1:0]  mc_cnt_q, mc_cnt_d;
    logic           start;

    // With MC_LAT=1 the FSM can never leave IDLE and synthesis removes it.
    assign start = start_i & MC_ON;

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        hold_o   = 1'b0;
        busy_o   = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (start) begin
                    hold_o   = 1'b1;
                    busy_o   = 1'b1;
                    state_d  = MC_RUN;
                    mc_cnt_d = CW'(MC_LAT - 2);
                end
            end
            MC_RUN: begin
                busy_o = 1'b1;
                if (mc_cnt_q != '0) begin
                    hold_o   = 1'b1;
                    mc_cnt_d = mc_cnt_q - CW'(1);
                end else begin
                    state_d = MC_IDLE;
                end
            end
            default: state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MC_IDLE;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline controller: stalls, flushes, bubbles, EX/ID
// forwarding selects, multi-cycle EX hold and a saturating stall counter.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 8,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              imem_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_branch_i,
    input  logic              id_taken_i,
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic              ex_mc_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_flush_o,
    output logic              id_ex_bubble_o,
    output logic              ex_hold_o,
    output logic              ex_mem_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              fwd_id_a_o,
    output logic              fwd_id_b_o,
    output logic              mc_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam bit FWD_ON = (FWD_EN != 0);

    logic             mc_hold, mc_busy;
    logic             ex_id_hit, mem_id1, mem_id2;
    logic             mem_ex1, mem_ex2, wb_ex1, wb_ex2;
    logic             ds;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hazard_mc_timer #(.MC_LAT(MC_LAT)) u_mc_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (ex_mc_i),
        .hold_o  (mc_hold),
        .busy_o  (mc_busy)
    );

    function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                                 input logic [REG_AW-1:0] rs, input logic use_rs);
        return we && (rd != '0) && (rd == rs) && use_rs;
    endfunction

    always_comb begin
        ex_id_hit = hit(ex_regwrite_i, ex_rd_i, id_rs1_i, id_use_rs1_i)
                  | hit(ex_regwrite_i, ex_rd_i, id_rs2_i, id_use_rs2_i);
        mem_id1   = hit(mem_regwrite_i, mem_rd_i, id_rs1_i, id_use_rs1_i);
        mem_id2   = hit(mem_regwrite_i, mem_rd_i, id_rs2_i, id_use_rs2_i);
        mem_ex1   = hit(mem_regwrite_i, mem_rd_i, ex_rs1_i, 1'b1);
        mem_ex2   = hit(mem_regwrite_i, mem_rd_i, ex_rs2_i, 1'b1);
        wb_ex1    = hit(wb_regwrite_i, wb_rd_i, ex_rs1_i, 1'b1);
        wb_ex2    = hit(wb_regwrite_i, wb_rd_i, ex_rs2_i, 1'b1);

        // WB never stalls: the regfile writes through to same-cycle reads.
        ds = (ex_memread_i & ex_id_hit)
           | (id_branch_i & (ex_id_hit | (mem_memread_i & (mem_id1 | mem_id2))))
           | (!FWD_ON & (ex_id_hit | mem_id1 | mem_id2));
    end

    always_comb begin
        pc_write_o      = 1'b1;
        if_id_write_o   = 1'b1;
        if_flush_o      = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_hold_o       = 1'b0;
        ex_mem_bubble_o = 1'b0;
        fwd_a_o         = FWD_REG;
        fwd_b_o         = FWD_REG;
        fwd_id_a_o      = 1'b0;
        fwd_id_b_o      = 1'b0;
        mc_busy_o       = 1'b0;

        if (rst_i) begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            if_flush_o      = 1'b1;
            id_ex_bubble_o  = 1'b1;
            ex_mem_bubble_o = 1'b1;
        end else begin
            mc_busy_o = mc_busy;
            ex_hold_o = mc_hold;
            if (mc_hold) begin
                // ID/EX is frozen, not bubbled: the op must stay in EX.
                pc_write_o      = 1'b0;
                if_id_write_o   = 1'b0;
                ex_mem_bubble_o = 1'b1;
            end else if (ds) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end else if (id_taken_i) begin
                if_flush_o = 1'b1;
            end else if (!imem_valid_i) begin
                pc_write_o = 1'b0;
                if_flush_o = 1'b1;
            end

            if (FWD_ON) begin
                fwd_a_o    = mem_ex1 ? FWD_MEM : (wb_ex1 ? FWD_WB : FWD_REG);
                fwd_b_o    = mem_ex2 ? FWD_MEM : (wb_ex2 ? FWD_WB : FWD_REG);
                fwd_id_a_o = mem_id1 & ~mem_memread_i;
                fwd_id_b_o = mem_id2 & ~mem_memread_i;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default build, a no-forwarding
// build and a MC_LAT=1 / narrow-counter build share one set of inputs.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_valid;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, id_branch, id_taken;
    logic       ex_regwrite, ex_memread, ex_mc;
    logic       mem_regwrite, mem_memread, wb_regwrite;

    logic        pc_w, ifid_w, flush, idex_bub, hold, exmem_bub, fida, fidb, busy;
    logic [1:0]  fa, fb;
    logic [15:0] scnt;

    logic        nf_pc_w, nf_ifid_w, nf_flush, nf_idex_bub, nf_hold, nf_exmem_bub;
    logic        nf_fida, nf_fidb, nf_busy;
    logic [1:0]  nf_fa, nf_fb;
    logic [15:0] nf_scnt;

    logic        s_pc_w, s_ifid_w, s_flush, s_idex_bub, s_hold, s_exmem_bub;
    logic        s_fida, s_fidb, s_busy;
    logic [1:0]  s_fa, s_fb;
    logic [2:0]  s_scnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_stall    = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .imem_valid_i(imem_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_branch_i(id_branch), .id_taken_i(id_taken),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
        .ex_memread_i(ex_memread), .ex_mc_i(ex_mc),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_memread_i(mem_memread),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_flush_o(flush), .id_ex_bubble_o(idex_bub),
        .ex_hold_o(hold), .ex_mem_bubble_o(exmem_bub), .fwd_a_o(fa), .fwd_b_o(fb),
        .fwd_id_a_o(fida), .fwd_id_b_o(fidb), .mc_busy_o(busy), .stall_cnt_o(scnt)
    );

    pipeline_hazard_ctrl #(.FWD_EN(0)) dut_nf (
        .clk_i(clk), .rst_i(rst), .imem_valid_i(imem_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_branch_i(id_branch), .id_taken_i(id_taken),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
        .ex_memread_i(ex_memread), .ex_mc_i(ex_mc),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_memread_i(mem_memread),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
        .pc_write_o(nf_pc_w), .if_id_write_o(nf_ifid_w), .if_flush_o(nf_flush), .id_ex_bubble_o(nf_idex_bub),
        .ex_hold_o(nf_hold), .ex_mem_bubble_o(nf_exmem_bub), .fwd_a_o(nf_fa), .fwd_b_o(nf_fb),
        .fwd_id_a_o(nf_fida), .fwd_id_b_o(nf_fidb), .mc_busy_o(nf_busy), .stall_cnt_o(nf_scnt)
    );

    pipeline_hazard_ctrl #(.MC_LAT(1), .CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_i(rst), .imem_valid_i(imem_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
        .id_branch_i(id_branch), .id_taken_i(id_taken),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite),
        .ex_memread_i(ex_memread), .ex_mc_i(ex_mc),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_memread_i(mem_memread),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
        .pc_write_o(s_pc_w), .if_id_write_o(s_ifid_w), .if_flush_o(s_flush), .id_ex_bubble_o(s_idex_bub),
        .ex_hold_o(s_hold), .ex_mem_bubble_o(s_exmem_bub), .fwd_a_o(s_fa), .fwd_b_o(s_fb),
        .fwd_id_a_o(s_fida), .fwd_id_b_o(s_fidb), .mc_busy_o(s_busy), .stall_cnt_o(s_scnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Idle pipeline: valid fetch, no register traffic.
    task automatic clear_inputs();
        imem_valid   = 1'b1;
        id_rs1       = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_branch    = 1'b0; id_taken = 1'b0;
        ex_rs1       = '0; ex_rs2 = '0; ex_rd = '0;
        ex_regwrite  = 1'b0; ex_memread = 1'b0; ex_mc = 1'b0;
        mem_rd       = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
        wb_rd        = '0; wb_regwrite = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs settle before checks.
    task automatic next_vec();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // reset
        @(negedge clk); settle();
        check("rst_pc_write", pc_w, 0);
        check("rst_if_id_write", ifid_w, 0);
        check("rst_flush", flush, 1);
        check("rst_id_ex_bubble", idex_bub, 1);
        check("rst_ex_mem_bubble", exmem_bub, 1);
        check("rst_hold", hold, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); settle();
        check("rst_stall_cnt", scnt, 0);

        next_vec(); rst = 1'b0; settle();
        check("idle_pc_write", pc_w, 1);
        check("idle_stall_cnt", scnt, 0);

        // load-use stall then WB forward
        next_vec();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5; settle();
        check("lu_pc_write", pc_w, 0);
        check("lu_if_id_write", ifid_w, 0);
        check("lu_bubble", idex_bub, 1);
        exp_stall++;
        next_vec();
        wb_regwrite = 1; wb_rd = 5; ex_rs1 = 5; settle();
        check("lu_fwd_a_wb", fa, 2'b01);
        check("lu_next_pc_write", pc_w, 1);
        check("lu_stall_cnt", scnt, exp_stall);

        // MEM beats WB, x0 never forwards
        next_vec();
        mem_regwrite = 1; mem_rd = 3; wb_regwrite = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3; settle();
        check("b2b_fwd_a_mem", fa, 2'b10);
        check("b2b_fwd_b_mem", fb, 2'b10);
        check("nf_fwd_a_zero", nf_fa, 2'b00);
        next_vec();
        mem_regwrite = 1; wb_regwrite = 1; settle();
        check("x0_fwd_a", fa, 2'b00);
        next_vec();
        mem_regwrite = 1; mem_rd = 4; wb_regwrite = 1; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 4; settle();
        check("mix_fwd_a_wb", fa, 2'b01);
        check("mix_fwd_b_mem", fb, 2'b10);

        // MEM RAW on ID source: forwarded normally, stalls without forwarding
        next_vec();
        mem_regwrite = 1; mem_rd = 3; id_use_rs1 = 1; id_rs1 = 3; settle();
        check("mem_raw_pc_write", pc_w, 1);
        check("mem_raw_fwd_id_a", fida, 1);
        check("nf_raw_pc_write", nf_pc_w, 0);
        check("nf_raw_bubble", nf_idex_bub, 1);
        check("nf_raw_fwd_id_a", nf_fida, 0);

        // branch operand stalls
        next_vec();
        id_branch = 1; id_use_rs1 = 1; id_rs1 = 7; ex_regwrite = 1; ex_rd = 7; settle();
        check("br_ex_pc_write", pc_w, 0);
        check("br_ex_bubble", idex_bub, 1);
        exp_stall++;
        next_vec();
        id_branch = 1; id_use_rs1 = 1; id_rs1 = 7; mem_regwrite = 1; mem_rd = 7; settle();
        check("br_mem_fwd_id_a", fida, 1);
        check("br_mem_pc_write", pc_w, 1);
        check("br_mem_stall_cnt", scnt, exp_stall);
        next_vec();
        id_branch = 1; id_use_rs2 = 1; id_rs2 = 7; mem_regwrite = 1; mem_memread = 1; mem_rd = 7; settle();
        check("br_load_pc_write", pc_w, 0);
        check("br_load_fwd_id_b", fidb, 0);
        exp_stall++;
        next_vec();
        id_use_rs2 = 1; id_rs2 = 7; mem_regwrite = 1; mem_memread = 1; mem_rd = 7; settle();
        check("alu_mem_load_pc_write", pc_w, 1);
        check("alu_mem_load_stall_cnt", scnt, exp_stall);
        next_vec();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5; settle();
        check("unused_src_pc_write", pc_w, 1);

        // fetch wait, and a taken branch redirecting despite no fetch
        next_vec();
        imem_valid = 0; settle();
        check("fw_pc_write", pc_w, 0);
        check("fw_if_id_write", ifid_w, 1);
        check("fw_flush", flush, 1);
        check("fw_bubble", idex_bub, 0);
        exp_stall++;
        next_vec();
        imem_valid = 0; id_branch = 1; id_taken = 1; settle();
        check("tk_flush", flush, 1);
        check("tk_pc_write", pc_w, 1);

        // multi-cycle op with a taken branch waiting behind it
        for (int i = 0; i < 8; i++) begin
            next_vec();
            ex_mc = 1; id_branch = 1; id_taken = 1; imem_valid = 0; settle();
            check("mc_busy", busy, 1);
            if (i < 7) begin
                check("mc_hold", hold, 1);
                check("mc_hold_pc_write", pc_w, 0);
                check("mc_hold_if_id_write", ifid_w, 0);
                check("mc_hold_flush", flush, 0);
                check("mc_hold_ex_mem_bubble", exmem_bub, 1);
                check("mc_hold_id_ex_bubble", idex_bub, 0);
                exp_stall++;
            end else begin
                check("mc_release_hold", hold, 0);
                check("mc_release_flush", flush, 1);
                check("mc_release_pc_write", pc_w, 1);
            end
            if (i == 0) begin
                check("lat1_hold", s_hold, 0);
                check("lat1_busy", s_busy, 0);
            end
        end
        next_vec(); settle();
        check("mc_after_hold", hold, 0);
        check("mc_after_busy", busy, 0);
        check("mc_stall_cnt", scnt, exp_stall);

        // reset in the middle of a RUN
        for (int i = 0; i < 3; i++) begin
            next_vec();
            ex_mc = 1; settle();
            check("mc2_hold", hold, 1);
        end
        next_vec();
        ex_mc = 1; rst = 1; settle();
        check("mid_rst_hold", hold, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flush", flush, 1);
        next_vec();
        rst = 0; settle();
        check("post_rst_hold", hold, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_stall_cnt", scnt, 0);
        check("post_rst_pc_write", pc_w, 1);

        // saturation of the narrow counter
        for (int i = 0; i < 10; i++) begin
            next_vec();
            imem_valid = 0;
        end
        next_vec(); settle();
        check("sat_cnt", s_scnt, 3'd7);
        check("wide_cnt", scnt, 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
